// File: rtl/alu_mul_seq.sv
// Shares one ALU between the pipeline datapath and an unsigned 32x32->64
// shift-add multiplier that adds through the ALU one multiplier bit per cycle.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dp_in1,
  input  logic [31:0] dp_in2,
  input  logic [3:0]  dp_ctr,
  input  logic        start,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_res,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic [31:0] w_addend;
  logic        w_carry;

  // Next-state decode: RUN lasts exactly 32 cycles, DONE exactly one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
        else       w_next = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == 6'd31) w_next = S_DONE;
        else                w_next = S_RUN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU input mux; the ALU has no carry-out, so the add carry is rebuilt from MSBs.
  always_comb begin
    w_addend = r_lo[0] ? r_mand : 32'd0;
    w_carry  = (r_hi[31] & w_addend[31]) |
               ((r_hi[31] | w_addend[31]) & ~alu_res[31]);
    if (r_state == S_RUN) begin
      alu_in1 = r_hi;
      alu_in2 = w_addend;
      alu_ctr = 4'b0010;
    end else begin
      alu_in1 = dp_in1;
      alu_in2 = dp_in2;
      alu_ctr = dp_ctr;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Multiplier registers: load on accepted start, shift the 65-bit sum right each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mand <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_cnt  <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mand <= mul_a;
            r_hi   <= 32'd0;
            r_lo   <= mul_b;
            r_cnt  <= 6'd0;
          end
        end
        S_RUN: begin
          {r_hi, r_lo} <= {w_carry, alu_res, r_lo[31:1]};
          r_cnt        <= r_cnt + 6'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized + directed bench for alu_mul_seq with a behavioural ALU and an
// arithmetic model of the partial products.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] dp_in1;
  logic [31:0] dp_in2;
  logic [3:0]  dp_ctr;
  logic        start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_fail;

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dp_in1  (dp_in1),
    .dp_in2  (dp_in2),
    .dp_ctr  (dp_ctr),
    .start   (start),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_ctr (alu_ctr),
    .alu_res (alu_res),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple reference ALU
  always_comb begin
    case (alu_ctr)
      4'b0000: alu_res = alu_in1 & alu_in2;
      4'b0001: alu_res = alu_in1 | alu_in2;
      4'b0010: alu_res = alu_in1 + alu_in2;
      4'b0110: alu_res = alu_in1 - alu_in2;
      default: alu_res = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full multiply starting in the current cycle; optional ignored start pulses.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit pulse);
    logic [63:0] prod;
    logic [63:0] pk;
    logic [63:0] acc;
    logic [31:0] hi_exp;
    logic [31:0] in2_exp;
    prod   = {32'd0, a} * {32'd0, b};
    dp_in1 = $urandom;
    dp_in2 = $urandom;
    dp_ctr = 4'b0110;
    mul_a  = a;
    mul_b  = b;
    start  = 1'b1;
    #1;
    chk("accept_busy", {63'd0, busy}, 64'd0);
    chk("accept_pass_in1", {32'd0, alu_in1}, {32'd0, dp_in1});
    chk("accept_pass_ctr", {60'd0, alu_ctr}, {60'd0, dp_ctr});
    step();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (pulse && k == 4) begin
        start = 1'b1;
        mul_a = $urandom;
        mul_b = $urandom;
      end
      if (pulse && k == 5) start = 1'b0;
      #1;
      pk      = {32'd0, a} * ({32'd0, b} & ((64'd1 << k) - 64'd1));
      acc     = pk << (32 - k);
      hi_exp  = acc[63:32];
      in2_exp = b[k] ? a : 32'd0;
      chk("run_busy", {63'd0, busy}, 64'd1);
      chk("run_done", {63'd0, done}, 64'd0);
      chk("run_ctr", {60'd0, alu_ctr}, 64'd2);
      chk("run_in1", {32'd0, alu_in1}, {32'd0, hi_exp});
      chk("run_in2", {32'd0, alu_in2}, {32'd0, in2_exp});
      step();
    end
    if (pulse) begin
      start = 1'b1;
      mul_a = $urandom;
      mul_b = $urandom;
    end
    #1;
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd1);
    chk("done_hi", {32'd0, hi}, {32'd0, prod[63:32]});
    chk("done_lo", {32'd0, lo}, {32'd0, prod[31:0]});
    chk("done_pass_in1", {32'd0, alu_in1}, {32'd0, dp_in1});
    chk("done_pass_ctr", {60'd0, alu_ctr}, {60'd0, dp_ctr});
    step();
    start = 1'b0;
    chk("after_busy", {63'd0, busy}, 64'd0);
    chk("after_done", {63'd0, done}, 64'd0);
    chk("after_hi", {32'd0, hi}, {32'd0, prod[63:32]});
    chk("after_lo", {32'd0, lo}, {32'd0, prod[31:0]});
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mul_a  = 32'd0;
    mul_b  = 32'd0;
    dp_in1 = 32'd5;
    dp_in2 = 32'd3;
    dp_ctr = 4'b0110;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("pass_in1", {32'd0, alu_in1}, 64'd5);
    chk("pass_in2", {32'd0, alu_in2}, 64'd3);
    chk("pass_ctr", {60'd0, alu_ctr}, 64'd6);
    chk("pass_res", {32'd0, alu_res}, 64'd2);
    step();

    do_mul(32'd7, 32'd6, 1'b0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mul(32'h80000000, 32'd2, 1'b0);
    do_mul(32'd7, 32'd6, 1'b1);
    do_mul(32'd0, 32'h12345678, 1'b0);
    for (int i = 0; i < 8; i++) do_mul($urandom, $urandom, (i % 2) == 1);

    // Abort mid-multiply with an asynchronous reset
    mul_a = 32'hDEADBEEF;
    mul_b = 32'hFFFFFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_pass_in1", {32'd0, alu_in1}, {32'd0, dp_in1});
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end

    do_mul($urandom, $urandom, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle controller that owns the ALU's input mux and shares the single ALU between the pipeline datapath and an unsigned 32x32->64 shift-add multiplier. The multiplier adds through the ALU (aluCtr 4'b0010) one bit per cycle. When idle, the block is a transparent pass-through for datapath ALU operations. It sits between the decode/execute stage and the ALU instance. While busy it asserts `busy` to stall the pipeline.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 4-bit ALU control, 6-bit iteration counter.
- `clk` input 1: rising-edge clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `dp_in1` input 32: datapath operand A.
- `dp_in2` input 32: datapath operand B.
- `dp_ctr` input 4: datapath ALU control code.
- `start` input 1: multiply request; sampled only in IDLE.
- `mul_a` input 32: multiplicand, captured on accepted `start`.
- `mul_b` input 32: multiplier, captured on accepted `start`.
- `alu_in1` output 32: ALU operand A.
- `alu_in2` output 32: ALU operand B.
- `alu_ctr` output 4: ALU control.
- `alu_res` input 32: ALU result (combinational return).
- `busy` output 1: 1 while the multiplier owns the ALU; datapath must stall.
- `done` output 1: one-cycle pulse when `hi`/`lo` become valid.
- `hi` output 32: product bits [63:32].
- `lo` output 32: product bits [31:0].

## Operation
- States: IDLE, RUN, DONE. Encoding is free. The state register is the only source of `busy`.
- IDLE:
  - `alu_in1`=`dp_in1`, `alu_in2`=`dp_in2`, `alu_ctr`=`dp_ctr`. This is combinational and zero-latency.
  - `start`=1 -> capture `mand`<=`mul_a`, `hi`<=0, `lo`<=`mul_b`, `cnt`<=0. Next state is RUN.
  - The ALU stays on the datapath during the accepting cycle.
- RUN (exactly 32 cycles):
  - `alu_in1`=`hi`, `alu_in2`=(`lo[0]` ? `mand` : 0), `alu_ctr`=4'b0010.
  - Carry is derived from MSBs because the ALU has no carry-out: `c` = (`in1[31]`&`in2[31]`) | ((`in1[31]`|`in2[31]`) & ~`alu_res[31]`).
  - Each cycle: {`hi`,`lo`} <= {`c`, `alu_res`, `lo[31:1]`}, which is a 65-bit value shifted right by 1. `cnt`<=`cnt`+1.
  - `cnt`==31 on a RUN edge -> next state is DONE.
- DONE (1 cycle):
  - `done`=1, `busy`=1.
  - ALU mux returns to the datapath. `dp_*` is driven through, but the pipeline is still stalled.
  - Next state is IDLE unconditionally.
- `start` in RUN/DONE is ignored. There is no queueing. The requester must re-assert `start` in IDLE.
- `hi`/`lo` hold their value from DONE until the next accepted `start`.
- `hi`/`lo` are intermediate values during RUN and are valid only from `done` onward.
- Multiplication is unsigned only. There is no early termination on zero operands.

## Timing
- Reset (async assert, sync-safe deassert by the system): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0, `mand`=0.
- ALU outputs follow `dp_*` immediately after reset.
- Reset mid-RUN aborts the multiply with no `done` pulse.
- Latency: `start` sampled at edge 0; RUN occupies cycles 1..32; DONE is cycle 33. `done`=1 and the product is valid in cycle 33.
- Throughput: the next `start` can be accepted at edge 34 at the earliest, i.e. 34 cycles per multiply.
- `busy` is registered: high from cycle 1 through cycle 33 inclusive, low in cycle 34.
- `done` is registered and high for exactly one cycle.
- All ALU-side outputs are combinational from state/registers/`dp_*`. There are no registered ALU inputs.
- `alu_res` is consumed in the same cycle. The ALU's path must close within one clock.

## Test plan
- Reset/pass-through: hold `rst_n`=0 -> `busy`=`done`=0, `hi`=`lo`=0. Release with `dp_in1`=5, `dp_in2`=3, `dp_ctr`=0110 -> `alu_in1`=5, `alu_in2`=3, `alu_ctr`=0110 in the same cycle.
- Basic multiply: `start` with `mul_a`=7, `mul_b`=6 -> `busy` high cycles 1-33, `done` at cycle 33, `hi`=0, `lo`=42. In RUN, `alu_ctr`=0010 every cycle.
- Carry path: 0xFFFFFFFF*0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Also 0x80000000*2 -> `hi`=1, `lo`=0.
- Ignored start: pulse `start` with new operands in RUN cycles 5 and 33 -> the product is unchanged (7*6=42) and no second `done`. `start` at cycle 34 is accepted.
- Reset mid-operation: assert `rst_n`=0 at cycle 10 of RUN -> state IDLE immediately, `busy`=0, no `done`, `hi`=`lo`=0.
- Zero operand: `mul_a`=0, `mul_b`=0x12345678 -> still 33-cycle latency, `hi`=`lo`=0, `alu_in2`=0 throughout RUN.
